nes_palette_ram: RTL
====================

NES_PALETTE_RAM -- requirements
Module: nes_palette_ram

Interface
REQ-001 Parameter NPAL, default 8: number of 4-entry palettes; total entries = 4*NPAL; NPAL is a power of two, 2 to 16.
REQ-002 Parameter DW, default 6: colour index width in bits; dout is 8 bits with bits above DW-1 driven 0.
REQ-003 Parameter INIT_EN, default 1: 1 = load default contents after reset; 0 = clear every entry to 0 after reset.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cpu_req  input  1  CPU access request; held high until cpu_ack.
REQ-007 cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-008 cpu_addr  input  $clog2(4*NPAL)  CPU entry address.
REQ-009 cpu_wdata  input  8  write data; only bits DW-1:0 are stored.
REQ-010 cpu_ack  output  1  one-cycle pulse marking access completion.
REQ-011 cpu_rdata  output  8  read data; valid while cpu_ack is high.
REQ-012 pix_addr  input  $clog2(4*NPAL)  renderer lookup address.
REQ-013 pix_grey  input  1  greyscale mode enable.
REQ-014 dout  output  8  renderer colour; registered.
REQ-015 ready  output  1  high once initialisation is complete.

Function
REQ-016 The FSM SHALL have exactly three states: INIT, IDLE, ACK.
REQ-017 INIT: write entry k on cycle k for k = 0..4*NPAL-1, using the default table if INIT_EN=1 and 0 otherwise; move to IDLE after the last entry; ready SHALL rise on the first IDLE cycle.
REQ-018 In INIT, cpu_req SHALL be ignored and cpu_ack held 0; the request stays pending and is served in IDLE.
REQ-019 IDLE with cpu_req=1: perform the access at the mirrored address this cycle (write commits at this edge), go to ACK; cpu_ack=1 during the ACK cycle; ACK returns unconditionally to IDLE.
REQ-020 A request still high on the cycle after ACK SHALL be treated as a new access; one access per two cycles maximum.
REQ-021 Mirroring: any address with bits 1:0 = 00 SHALL map to entry 0 for both CPU and pixel ports (universal background); all other addresses map to themselves.
REQ-022 cpu_rdata SHALL return the stored value zero-extended to 8 bits, registered at the request edge, held until the next access.
REQ-023 dout SHALL equal entry[mirror(pix_addr)] one cycle after pix_addr is presented (latency 1), every cycle, independent of the CPU port.
REQ-024 Same-cycle CPU write and pixel read of the same entry: dout SHALL show the old value that cycle and the new value on the following lookup (no bypass).
REQ-025 With pix_grey=1, dout SHALL be the entry value ANDed with 0x30 when DW=6; for DW>6, only bits DW-1:4 are kept.
REQ-026 Until ready=1, dout SHALL be 0.

Reset
REQ-027 While rst_n=0: state=INIT, init counter=0, ready=0, cpu_ack=0, cpu_rdata=0, dout=0; storage contents are undefined.
REQ-028 Reset asserted mid-operation, in any state, SHALL abort it, and a full re-initialisation SHALL follow release.

Structure
REQ-029 A package nes_palette_pkg SHALL hold the FSM state enum, the mirror function, and the 32-entry default table (8 palettes: 06 2D 27 30 / 06 30 1A 09 / 06 2D 27 30 / 06 27 17 0F / 06 3C 27 30 / 06 21 26 20 / 06 26 2C 30 / 06 27 2A 30, hex).
REQ-030 For NPAL>8, the default table SHALL repeat modulo 32; for NPAL<8, the first 4*NPAL entries SHALL be used.
REQ-031 One sub-module, nes_palette_init_rom, SHALL be combinational: init address in, default entry out.

Verification
REQ-032 Release reset, count cycles: ready rises after exactly 32 cycles (NPAL=8); a pixel sweep then returns the default table with mirroring (addr 0x14 -> 0x06).
REQ-033 Write 0x0F to addr 0x10 -> cpu_ack the next cycle; a pixel read of addr 0x00 returns 0x0F.
REQ-034 Hold cpu_req during INIT -> no ack until ready; then exactly one ack, with no duplicate write.
REQ-035 Write 0x2A to addr 5 in the same cycle pix_addr=5 -> dout shows 0x30 (the default), then 0x2A the next cycle.
REQ-036 pix_grey=1 at addr 0x1E (0x2A) -> dout 0x20; pix_grey=0 -> dout 0x2A.
REQ-037 Pulse rst_n low during ACK -> cpu_ack=0 immediately; full re-initialisation; the earlier write is overwritten by defaults.

Source files
------------

// File: rtl/nes_palette_pkg.sv
// Shared types, the address mirror and the power-on palette table for the
// NES-style palette RAM.
package nes_palette_pkg;

  // Controller states: fill storage, wait for CPU, acknowledge CPU.
  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ACK
  } pal_state_e;

  // Widest entry address ever needed (16 palettes * 4 entries).
  localparam int MAX_AW    = 6;
  localparam int TABLE_LEN = 32;

  // Power-on contents: eight 4-entry palettes, repeated modulo 32 for
  // larger RAMs and truncated for smaller ones.
  localparam logic [7:0] DEFAULT_TABLE [TABLE_LEN] = '{
    8'h06, 8'h2D, 8'h27, 8'h30,
    8'h06, 8'h30, 8'h1A, 8'h09,
    8'h06, 8'h2D, 8'h27, 8'h30,
    8'h06, 8'h27, 8'h17, 8'h0F,
    8'h06, 8'h3C, 8'h27, 8'h30,
    8'h06, 8'h21, 8'h26, 8'h20,
    8'h06, 8'h26, 8'h2C, 8'h30,
    8'h06, 8'h27, 8'h2A, 8'h30
  };

  // Entry 0 of every palette is the shared background colour, so any
  // address with the low two bits clear folds onto entry 0.
  function automatic logic [MAX_AW-1:0] mirror(input logic [MAX_AW-1:0] addr);
    return (addr[1:0] == 2'b00) ? '0 : addr;
  endfunction

endpackage

// File: rtl/nes_palette_init_rom.sv
// Combinational lookup of the power-on palette contents by init address.
module nes_palette_init_rom
  import nes_palette_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] addr_i,
  output logic [7:0]    data_o
);

  logic [4:0] tableIdx;

  // Wrap the address onto the 32-entry table and read the default colour.
  always_comb begin
    tableIdx = 5'(addr_i);
    data_o   = DEFAULT_TABLE[tableIdx];
  end

endmodule

// File: rtl/nes_palette_ram.sv
// Palette RAM with a self-initialising controller, a handshaked CPU port and
// a one-cycle-latency renderer lookup port with greyscale masking.
module nes_palette_ram
  import nes_palette_pkg::*;
#(
  parameter int NPAL    = 8,
  parameter int DW      = 6,
  parameter bit INIT_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [$clog2(4*NPAL)-1:0]    cpu_addr,
  input  logic [7:0]                   cpu_wdata,
  output logic                         cpu_ack,
  output logic [7:0]                   cpu_rdata,
  input  logic [$clog2(4*NPAL)-1:0]    pix_addr,
  input  logic                         pix_grey,
  output logic [7:0]                   dout,
  output logic                         ready
);

  localparam int DEPTH = 4 * NPAL;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [DW-1:0] GREY_MASK = {DW{1'b1}} << 4;

  logic [DW-1:0] mem [DEPTH];

  pal_state_e    state_q, state_d;
  logic [AW-1:0] initCnt_q, initCnt_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    dout_q, dout_d;

  logic          memWe;
  logic [AW-1:0] memWaddr;
  logic [DW-1:0] memWdata;
  logic [AW-1:0] cpuIdx;
  logic [AW-1:0] pixIdx;
  logic [DW-1:0] cpuVal;
  logic [DW-1:0] pixVal;
  logic [7:0]    romData;

  nes_palette_init_rom #(
    .AW(AW)
  ) u_init_rom (
    .addr_i (initCnt_q),
    .data_o (romData)
  );

  // Fold both ports' addresses onto real storage and read them asynchronously.
  always_comb begin
    cpuIdx = AW'(mirror(MAX_AW'(cpu_addr)));
    pixIdx = AW'(mirror(MAX_AW'(pix_addr)));
    cpuVal = mem[cpuIdx];
    pixVal = mem[pixIdx];
  end

  // Controller: sweep storage once after reset, then serve one CPU access per two cycles.
  always_comb begin
    state_d   = state_q;
    initCnt_d = initCnt_q;
    rdata_d   = rdata_q;
    memWe     = 1'b0;
    memWaddr  = initCnt_q;
    memWdata  = '0;
    case (state_q)
      INIT: begin
        memWe     = 1'b1;
        memWaddr  = initCnt_q;
        memWdata  = INIT_EN ? DW'(romData) : '0;
        initCnt_d = initCnt_q + 1'b1;
        if (initCnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cpu_req) begin
          state_d = ACK;
          if (cpu_we) begin
            memWe    = 1'b1;
            memWaddr = cpuIdx;
            memWdata = DW'(cpu_wdata);
          end else begin
            rdata_d = 8'(cpuVal);
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Renderer colour: blanked until ready, optionally reduced to luminance bits; reads see pre-write contents.
  always_comb begin
    dout_d = '0;
    if (state_q != INIT) begin
      dout_d = 8'(pix_grey ? (pixVal & GREY_MASK) : pixVal);
    end
  end

  // Storage has no reset; the INIT sweep defines its contents.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  // Control and output registers, cleared asynchronously so reset aborts any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      initCnt_q <= '0;
      rdata_q   <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      initCnt_q <= initCnt_d;
      rdata_q   <= rdata_d;
      dout_q    <= dout_d;
    end
  end

  assign cpu_ack   = (state_q == ACK);
  assign ready     = (state_q != INIT);
  assign cpu_rdata = rdata_q;
  assign dout      = dout_q;

endmodule
